sprite_rom_arbiter: RTL

Shares the single-read-port sprite ROM (spriteRAM: 18-bit address, 5-bit palette index, 1-cycle registered read) among several pixel-fetch requesters (map background, player sprites, projectile, tile renderer). Each requester names a sprite by ID plus a pixel offset. The block translates that pair to an absolute ROM address, grants one requester per cycle round-robin, and returns the palette index tagged with the requester ID two cycles after acceptance. It sits between the per-layer draw logic and spriteRAM in the color-mapper path.

---
 rtl/sprite_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/sprite_rom_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Sprite ROM layout shared by the fetch arbiter: IDs, bases, sizes.
// Widths and the ROM depth for the single-port spriteRAM.
package sprite_pkg;

   localparam int ADDR_W      = 18;
   localparam int DATA_W      = 5;
   localparam int ROM_DEPTH   = 156331;
   localparam int NUM_SPRITES = 11;
   localparam int BLANK_ADDR  = 1706;

   typedef enum logic [3:0] {
      SPR_CANNONBALL   = 4'd0,
      SPR_DEMO_R_RED   = 4'd1,
      SPR_DEMO_L_RED   = 4'd2,
      SPR_DEMO_R_BLU   = 4'd3,
      SPR_DEMO_L_BLU   = 4'd4,
      SPR_SKY          = 4'd5,
      SPR_GROUND       = 4'd6,
      SPR_BLANKING     = 4'd7,
      SPR_MAP1         = 4'd8,
      SPR_MAP2         = 4'd9,
      SPR_TILE_STONE   = 4'd10
   } sprite_id_e;

   localparam int unsigned SPRITE_BASE [NUM_SPRITES] = '{
      0, 204, 579, 954, 1329, 1704, 1705, 1706, 1707, 78507, 155307
   };

   localparam int unsigned SPRITE_SIZE [NUM_SPRITES] = '{
      204, 375, 375, 375, 375, 1, 1, 1, 76800, 76800, 1024
   };

   // Unused IDs map to base 0 and size 0.
   function automatic int unsigned sprite_base(input logic [3:0] id);
      return (id < 4'(NUM_SPRITES)) ? SPRITE_BASE[id] : 0;
   endfunction

   function automatic int unsigned sprite_size(input logic [3:0] id);
      return (id < 4'(NUM_SPRITES)) ? SPRITE_SIZE[id] : 0;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts at rr_ptr and wraps.
// Pointer moves past the winner on each accepted grant.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     idx
);

   logic [IDW-1:0] rr_ptr;
   logic           found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
            found = 1'b1;
            gnt[(int'(rr_ptr) + i) % NUM_REQ] = 1'b1;
            idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (en && found) begin
         rr_ptr <= (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares spriteRAM among pixel fetchers; 2-cycle tagged responses.
// Optional bounds check: define SPRITE_ARB_BOUNDS_CHECK_EN.
module sprite_rom_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int ADDR_W  = 18,
   parameter  int DATA_W  = 5,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*4-1:0]      req_sprite,
   input  logic [NUM_REQ*ADDR_W-1:0] req_offset,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]         ram_address,
   input  logic [DATA_W-1:0]         ram_q,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [IDW-1:0]            rsp_id,
   output logic                      oob_err
);

   import sprite_pkg::*;

   logic [NUM_REQ-1:0] gnt;
   logic [IDW-1:0]     gidx;
   logic               acc;
   logic [3:0]         sid;
   logic [ADDR_W-1:0]  off;
   logic [ADDR_W-1:0]  sum;
   logic [ADDR_W-1:0]  addr;
   logic               oob;

   logic               s1_valid, s2_valid;
   logic [IDW-1:0]     s1_id, s2_id;
   logic               s1_oob, s2_oob;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clock (clock),
      .reset (reset),
      .req   (req_valid & {NUM_REQ{~reset}}),
      .en    (~reset),
      .gnt   (gnt),
      .idx   (gidx)
   );

   assign req_ready = gnt;
   assign acc       = |gnt;
   assign sid       = req_sprite[int'(gidx)*4 +: 4];
   assign off       = req_offset[int'(gidx)*ADDR_W +: ADDR_W];

   // Sum is one bit wider, then wraps into the ROM address space.
   assign sum = ADDR_W'({1'b0, off} + (ADDR_W+1)'(sprite_base(sid)));

`ifdef SPRITE_ARB_BOUNDS_CHECK_EN
   assign oob  = (sid >= 4'(NUM_SPRITES)) ||
                 (32'(off) >= sprite_size(sid));
   assign addr = oob ? ADDR_W'(BLANK_ADDR) : sum;
`else
   assign oob  = 1'b0;
   assign addr = sum;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         ram_address <= '0;
         s1_valid    <= 1'b0;
         s1_id       <= '0;
         s1_oob      <= 1'b0;
         s2_valid    <= 1'b0;
         s2_id       <= '0;
         s2_oob      <= 1'b0;
      end else begin
         s1_valid <= acc;
         if (acc) begin
            ram_address <= addr;
            s1_id       <= gidx;
            s1_oob      <= oob;
         end
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
         s2_oob   <= s1_oob;
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (s2_valid) rsp_valid[s2_id] = 1'b1;
   end

   assign rsp_id   = s2_id;
   assign rsp_data = s2_oob ? '0 : ram_q;
   assign oob_err  = s2_valid & s2_oob;

endmodule
